// File: rtl/cmd_dispatch.sv
// ---------------------------------------------------------------------------
// cmd_dispatch
// Byte-stream command decoder between the RX FIFO (FT245 side) and the
// controller blocks. It pops an opcode plus 0-2 payload bytes, then does one of:
// write or read a settings register file, forward a 16-bit word to a busy-gated
// peripheral, or pulse one of a set of strobe lines. It also provides register
// readback, an inter-byte timeout and a saturating error counter.
//
// Opcodes (payload bytes):
//   0x01 WRITE_REG (addr, data)   0x02 READ_REG (addr)
//   0x03 WRITE_EXT (msb, lsb)     0x04 SOFT_RESET
//   0x10+k STROBE k, k < NUM_STROBES
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   rx_rdata      RX FIFO head byte (first-word-fall-through)
//   rx_rempty     RX FIFO empty
//   rx_hold       FT245 busy, no pop while high
//   rx_rinc       pop strobe (combinational)
//   regs          register file, reg k = regs[8k+7:8k]
//   strobe        one-hot strobe pulses, STROBE_LEN cycles wide
//   ext_data      forwarded word {msb, lsb}
//   ext_valid     ext_data valid, held until ext_ready
//   ext_ready     peripheral not busy
//   resp_data     readback {addr, data}
//   resp_avail    response valid, held until resp_accept
//   resp_accept   response taken
//   soft_rst      one-cycle pulse on SOFT_RESET
//   busy          decoder is not idle
//   err_count     saturating error counter
// ---------------------------------------------------------------------------
module cmd_dispatch #(
  parameter int                    NUM_REGS    = 4,
  parameter logic [NUM_REGS*8-1:0] REG_RST     = '0,
  parameter int                    NUM_STROBES = 4,
  parameter int                    STROBE_LEN  = 2,
  parameter int                    TIMEOUT     = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_rdata,
  input  logic                    rx_rempty,
  input  logic                    rx_hold,
  output logic                    rx_rinc,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic [NUM_STROBES-1:0]  strobe,
  output logic [15:0]             ext_data,
  output logic                    ext_valid,
  input  logic                    ext_ready,
  output logic [15:0]             resp_data,
  output logic                    resp_avail,
  input  logic                    resp_accept,
  output logic                    soft_rst,
  output logic                    busy,
  output logic [7:0]              err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAY,
    S_EXEC,
    S_WAIT_EXT,
    S_WAIT_RESP,
    S_STROBE
  } state_t;

  localparam logic [7:0] OP_WRITE_REG  = 8'h01;
  localparam logic [7:0] OP_READ_REG   = 8'h02;
  localparam logic [7:0] OP_WRITE_EXT  = 8'h03;
  localparam logic [7:0] OP_SOFT_RESET = 8'h04;

  localparam bit                     TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0]            TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]            STB_LAST = 16'(STROBE_LEN - 1);
  localparam logic [NUM_STROBES-1:0] STB_ONE  = NUM_STROBES'(1);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [7:0]  pay0_q;       // addr or msb
  logic [7:0]  pay1_q;       // data or lsb
  logic        pay_first_q;  // next payload byte goes to pay0_q
  logic [1:0]  pay_need_q;   // payload bytes still to pop
  logic [15:0] tmo_q;        // idle cycles since the last pop
  logic [15:0] stb_cnt_q;    // strobe cycles remaining after this one

  logic        op_ok;
  logic [1:0]  op_len;
  logic        addr_ok;
  logic [7:0]  rd_byte;
  logic        tmo_hit;
  logic        err_inc;

  function automatic logic is_strobe_op(input logic [7:0] op);
    return (op[7:4] == 4'h1) && ({1'b0, op[3:0]} < 5'(NUM_STROBES));
  endfunction

  assign rx_rinc = ((state_q == S_IDLE) || (state_q == S_PAY)) && !rx_rempty && !rx_hold;
  assign busy    = (state_q != S_IDLE);
  assign addr_ok = ({1'b0, pay0_q} < 9'(NUM_REGS));
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  // Opcode decode on the FIFO head byte; only meaningful while popping in IDLE.
  // NOTE: every always_comb output gets a default before any branch so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    op_ok  = 1'b1;
    op_len = 2'd0;
    case (rx_rdata)
      OP_WRITE_REG,
      OP_WRITE_EXT:  op_len = 2'd2;
      OP_READ_REG:   op_len = 2'd1;
      OP_SOFT_RESET: op_len = 2'd0;
      default:       op_ok  = is_strobe_op(rx_rdata);
    endcase
  end

  // Readback mux; out-of-range addresses read as zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (pay0_q == 8'(k)) rd_byte = regs[8*k +: 8];
    end
  end

  // Next state. Error sources live in mutually exclusive states, so a single
  // flag naturally counts simultaneous causes once.
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_rinc) begin
          if (!op_ok)             err_inc = 1'b1;
          else if (op_len == 2'd0) state_d = S_EXEC;
          else                     state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (rx_rinc) begin
          if (pay_need_q == 2'd1) state_d = S_EXEC;
        end else if (tmo_hit) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_WRITE_REG: begin
            err_inc = !addr_ok;
            state_d = S_IDLE;
          end
          OP_READ_REG: begin
            err_inc = !addr_ok;
            state_d = S_WAIT_RESP;
          end
          OP_WRITE_EXT:  state_d = S_WAIT_EXT;
          OP_SOFT_RESET: state_d = S_IDLE;
          default:       state_d = S_STROBE;  // only strobe opcodes reach EXEC
        endcase
      end
      S_WAIT_EXT:  if (ext_ready)   state_d = S_IDLE;
      S_WAIT_RESP: if (resp_accept) state_d = S_IDLE;
      S_STROBE:    if (stb_cnt_q == 16'd0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath. The register file is reset because its reset image (REG_RST) is
  // architecturally visible and restored by SOFT_RESET as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q    <= 8'h00;
      pay0_q      <= 8'h00;
      pay1_q      <= 8'h00;
      pay_first_q <= 1'b0;
      pay_need_q  <= 2'd0;
      tmo_q       <= 16'd0;
      stb_cnt_q   <= 16'd0;
      regs        <= REG_RST;
      strobe      <= '0;
      ext_data    <= 16'h0000;
      ext_valid   <= 1'b0;
      resp_data   <= 16'h0000;
      resp_avail  <= 1'b0;
      soft_rst    <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      soft_rst <= 1'b0;
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (rx_rinc) begin
            opcode_q    <= rx_rdata;
            pay_need_q  <= op_len;
            pay_first_q <= 1'b1;
            tmo_q       <= 16'd0;
          end
        end
        S_PAY: begin
          if (rx_rinc) begin
            if (pay_first_q) pay0_q <= rx_rdata;
            else             pay1_q <= rx_rdata;
            pay_first_q <= 1'b0;
            pay_need_q  <= pay_need_q - 2'd1;
            tmo_q       <= 16'd0;
          end else begin
            // Keeps counting while rx_hold stalls the stream.
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_WRITE_REG: begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (pay0_q == 8'(k)) regs[8*k +: 8] <= pay1_q;
              end
            end
            OP_READ_REG: begin
              resp_data  <= {pay0_q, rd_byte};
              resp_avail <= 1'b1;
            end
            OP_WRITE_EXT: begin
              ext_data  <= {pay0_q, pay1_q};
              ext_valid <= 1'b1;
            end
            OP_SOFT_RESET: begin
              regs     <= REG_RST;
              soft_rst <= 1'b1;
            end
            default: begin
              strobe    <= STB_ONE << opcode_q[3:0];
              stb_cnt_q <= STB_LAST;
            end
          endcase
        end
        S_WAIT_EXT:  if (ext_ready)   ext_valid  <= 1'b0;
        S_WAIT_RESP: if (resp_accept) resp_avail <= 1'b0;
        S_STROBE: begin
          if (stb_cnt_q == 16'd0) strobe    <= '0;
          else                    stb_cnt_q <= stb_cnt_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
